main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
Synthesizable main-memory responder for the L2_cache memory-side port (mem_addr/mem_read/mem_write/mem_ready). Completes one word per request after a fixed, parameterized latency, and serves both line fills (reads) and write-backs (writes). Replaces the ad hoc bench memory model, so the L2 and the L1+L2 system benches run against one timed responder.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8
ADDR_WIDTH, 11, byte address width; 2048 B space
LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..255
INIT_BASE, 32'h1000, reset-free init pattern: word[i] = i*4 + INIT_BASE (loaded at time 0 only)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mem_addr  in  ADDR_WIDTH  byte address from L2
mem_data_in  in  DATA_WIDTH  write data from L2 (L2's mem_data_out)
mem_read  in  1  read request, level, held by L2 until mem_ready
mem_write  in  1  write request, level, held by L2 until mem_ready
mem_data_out  out  DATA_WIDTH  read data to L2 (L2's mem_data_in), registered
mem_ready  out  1  one-cycle completion pulse
busy  out  1  high in BUSY and RESP
rd_count  out  16  completed reads, saturating at 16'hFFFF
wr_count  out  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Storage: 2^ADDR_WIDTH/(DATA_WIDTH/8) words (512 at defaults). Word index = mem_addr >> 2; mem_addr[1:0] ignored. Contents are not cleared by reset.
- Reset (rst_n low at posedge): state=IDLE, mem_ready=0, mem_data_out=0, busy=0, rd_count=0, wr_count=0, counter=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: at a posedge with mem_read or mem_write high, latch addr, wdata and op, load counter = LATENCY-1, go to BUSY.
  - If both requests are high, the op is a write; the read is dropped.
- BUSY: decrement counter each posedge. At the posedge where counter==0, perform the op and go to RESP.
  - Read: mem_data_out <= word[idx].
  - Write: word[idx] <= latched wdata.
- RESP: mem_ready=1 for exactly this cycle. Next posedge goes to IDLE and increments the matching counter (saturating).
- Latency: request sampled at edge E0 -> mem_ready high during the cycle after edge E0+LATENCY.
- IDLE re-samples the request level, so an L2 that keeps mem_read high gets back-to-back words.
  - Spacing is LATENCY+2 cycles between ready pulses (RESP->IDLE->BUSY).
- Address and data changes during BUSY are ignored; the latched values are used.
- mem_data_out holds its last read value through writes and idle cycles.
- mem_ready is never high in two consecutive cycles.
- Reset mid-BUSY/RESP: the op is aborted with no write and no pulse. Reset asserted at the completing edge suppresses the write.

Decomposition:
- Package mem_resp_pkg:
  - state enum {IDLE, BUSY, RESP};
  - op enum {OP_RD, OP_WR};
  - localparam WORDS;
  - function word_index(addr).
- One sub-module, mem_word_array: single-port synchronous word RAM (we, idx, wdata, rdata) with the init loop. The FSM, latency counter and statistics stay in the top level.

Test Plan:
- Cold read: reset, mem_read=1 with mem_addr=20, LATENCY=4 -> mem_ready for one cycle exactly 5 edges after sampling; mem_data_out=32'h1014; rd_count=1.
- Line fill: mem_read held high, addr stepping 0,4,...,28 on each ready -> 8 pulses with data 32'h1000..32'h101C, spaced 6 cycles; rd_count=8.
- Write then read: mem_write, addr=0x40, data=32'hDEADBEEF -> ready pulse, wr_count=1, mem_data_out unchanged; then read addr 0x40 -> 32'hDEADBEEF.
- Boundaries:
  - addr 22 returns the same word as addr 20 (32'h1014);
  - addr 0x7FC returns 32'h17FC;
  - read+write together at addr 8 with data 32'h5 -> treated as write; read of 8 -> 32'h5, rd_count unchanged by the combined request.
- Reset mid-op: write accepted, rst_n low for 1 cycle during BUSY -> no mem_ready, memory word unchanged, counters 0, busy=0.
- Saturation: force rd_count to 16'hFFFE, complete 3 reads -> holds at 16'hFFFF.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the main-memory responder: FSM states, operation kind,
// default geometry and the byte-address to word-index helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 11;
    localparam int unsigned WORDS =
        (1 << DEF_ADDR_WIDTH) / (DEF_DATA_WIDTH / 8);

    // Sub-word byte offset bits are dropped.
    function automatic int unsigned word_index(
        input logic [31:0] addr,
        input int unsigned bytes_per_word
    );
        return addr / bytes_per_word;
    endfunction

endpackage

// File: rtl/main_memory_responder_mem_word_array.sv
// Word RAM behind the responder: synchronous write, combinational read.
// Ports: clk, we_i, idx_i (word index), wdata_i, rdata_o.
module mem_word_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 9,
    parameter logic [31:0] INIT_BASE  = 32'h1000
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned NWORDS = 1 << IDX_W;

    typedef logic [NWORDS-1:0][DATA_WIDTH-1:0] image_t;

    // Power-up image word[i] = i*4 + INIT_BASE; reset never clears it.
    function automatic image_t init_image();
        image_t img;
        for (int i = 0; i < NWORDS; i++) begin
            img[i] = DATA_WIDTH'(i * 4 + int'(INIT_BASE));
        end
        return img;
    endfunction

    image_t mem_q = init_image();

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/main_memory_responder.sv
// Timed main-memory responder for the L2 memory-side port: one word per
// request after LATENCY cycles, reads (line fills) and writes (write-backs).
// Ports: mem_addr/mem_data_in/mem_read/mem_write from L2; mem_data_out,
// mem_ready pulse, busy, and saturating rd_count/wr_count statistics.
module main_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned LATENCY    = 4,
    parameter logic [31:0] INIT_BASE  = 32'h1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_ready,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = ADDR_WIDTH - $clog2(BPW);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;

    logic                  done;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign done    = (state_q == BUSY) && (cnt_q == 8'd0);
    assign ram_idx = IDX_W'(word_index(32'(addr_q), BPW));
    // Reset at the completing edge must suppress the write.
    assign ram_we  = done && (op_q == OP_WR) && rst_n;

    mem_word_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W),
        .INIT_BASE (INIT_BASE)
    ) u_array (
        .clk    (clk),
        .we_i   (ram_we),
        .idx_i  (ram_idx),
        .wdata_i(wdata_q),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    // Write wins when both are requested.
                    op_d    = mem_write ? OP_WR : OP_RD;
                    addr_d  = mem_addr;
                    wdata_d = mem_data_in;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    if (op_q == OP_RD) begin
                        dout_d = ram_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (op_q == OP_RD) begin
                    if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
                end else begin
                    if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_RD;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dout_q   <= dout_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign mem_data_out = dout_q;
    assign mem_ready    = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder against a word-array
// reference model with directed and random requests.
module tb_main_memory_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] mem_addr = '0;
    logic [31:0] mem_data_in = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_assert = 0;
    int n_fail = 0;

    logic [31:0] model [512];
    logic [31:0] m_last;
    logic [15:0] m_rd, m_wr;

    main_memory_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(11),
        .LATENCY   (LAT),
        .INIT_BASE (32'h1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_data_out(mem_data_out),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_rd_count"}, 32'(rd_count), 32'(m_rd));
        check({tag, "_wr_count"}, 32'(wr_count), 32'(m_wr));
    endtask

    // One request; inputs scrambled during BUSY to prove they are latched.
    task automatic txn(input bit rd, input bit wr, input logic [10:0] a,
                       input logic [31:0] d, input string tag);
        int  n;
        bit  got;
        @(negedge clk);
        mem_read    = rd;
        mem_write   = wr;
        mem_addr    = a;
        mem_data_in = d;
        @(posedge clk);
        n   = 0;
        got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                mem_addr    = 11'($urandom);
                mem_data_in = $urandom;
            end
            if (mem_ready) got = 1;
        end
        check({tag, "_latency"}, n, LAT + 1);
        if (wr) model[a[10:2]] = d;
        else m_last = model[a[10:2]];
        check({tag, "_data_out"}, mem_data_out, m_last);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        if (wr) m_wr = sat(m_wr);
        else m_rd = sat(m_rd);
        check({tag, "_ready_drop"}, 32'(mem_ready), 32'd0);
        check_counts(tag);
    endtask

    initial begin
        int  n;
        bit  seen;
        for (int i = 0; i < 512; i++) model[i] = 32'(i * 4 + 32'h1000);
        m_last = '0;
        m_rd   = '0;
        m_wr   = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", mem_data_out, 32'd0);
        check_counts("rst");

        txn(1, 0, 11'd20, 32'd0, "cold_read");
        check("cold_value", mem_data_out, 32'h1014);

        // Line fill with mem_read held high.
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 11'd0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            seen = 0;
            while (!seen && n < 200) begin
                @(negedge clk);
                n++;
                if (mem_ready) seen = 1;
            end
            check("fill_spacing", n, (k == 0) ? LAT + 1 : LAT + 2);
            check("fill_data", mem_data_out, 32'h1000 + 32'(k * 4));
            m_last = model[k];
            m_rd   = sat(m_rd);
            mem_addr = 11'((k + 1) * 4);
            if (k == 7) mem_read = 1'b0;
        end
        @(negedge clk);
        check_counts("fill");

        txn(0, 1, 11'h40, 32'hDEADBEEF, "wr40");
        txn(1, 0, 11'h40, 32'd0, "rd40");
        check("rd40_value", mem_data_out, 32'hDEADBEEF);
        txn(1, 0, 11'd22, 32'd0, "rd22");
        check("rd22_value", mem_data_out, 32'h1014);
        txn(1, 0, 11'h7FC, 32'd0, "rd7fc");
        check("rd7fc_value", mem_data_out, 32'h17FC);
        txn(1, 1, 11'd8, 32'h5, "both8");
        txn(1, 0, 11'd8, 32'd0, "rd8");
        check("rd8_value", mem_data_out, 32'h5);

        // Reset during BUSY aborts a write.
        @(negedge clk);
        mem_write   = 1'b1;
        mem_addr    = 11'h100;
        mem_data_in = 32'hCAFEF00D;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst_n     = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rd = '0;
        m_wr = '0;
        m_last = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dout", mem_data_out, 32'd0);
        check_counts("abort");
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (mem_ready) seen = 1;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        txn(1, 0, 11'h100, 32'd0, "abort_rd");
        check("abort_word", mem_data_out, 32'h1100);

        for (int t = 0; t < 24; t++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            txn(sel != 1, sel != 0, 11'($urandom), $urandom, "rand");
        end

        // Saturation of the read counter.
        @(negedge clk);
        force dut.rd_cnt_q = 16'hFFFE;
        #1 release dut.rd_cnt_q;
        m_rd = 16'hFFFE;
        for (int t = 0; t < 3; t++) begin
            txn(1, 0, 11'($urandom), 32'd0, "sat");
        end
        check("sat_final", 32'(rd_count), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
